// File: rtl/arbitration_pkg.sv
// Shared arbitration types for the bus masters and their request queues.
//   NUM_MASTERS : number of bus masters
//   arb_vector  : one bit per master (request / grant / status vectors)
//   rq_state_e  : per-master request-queue channel state
//   cnt_width() : width of a pending counter able to hold 0..depth
package arbitration;

  localparam int NUM_MASTERS = 3;

  typedef logic [NUM_MASTERS-1:0] arb_vector;

  typedef enum logic [1:0] {RQ_IDLE, RQ_WAIT, RQ_GRANTED} rq_state_e;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/req_queue_if.sv
// Client/bus side signal bundle of the request queue.
//   client_req  : one-cycle pulse per new transaction, per master
//   bus_grant   : arbiter grant vector (tap)
//   bus_ack     : slave acknowledge (tap)
//   master_req  : level request per master, high while transactions are pending
//   pending     : per-master pending count
//   overflow    : sticky, request arrived while full
//   starve      : master waited TIMEOUT cycles without a grant
//   busy        : any master requesting
// slave modport is the queue's view, master modport the driver's view.
interface req_queue_if import arbitration::*; #(
  parameter int DEPTH = 4
) ();

  localparam int CW = cnt_width(DEPTH);

  arb_vector                        client_req;
  arb_vector                        bus_grant;
  logic                             bus_ack;
  arb_vector                        master_req;
  logic [NUM_MASTERS-1:0][CW-1:0]   pending;
  arb_vector                        overflow;
  arb_vector                        starve;
  logic                             busy;

  modport slave (
    input  client_req, bus_grant, bus_ack,
    output master_req, pending, overflow, starve, busy
  );

  modport master (
    output client_req, bus_grant, bus_ack,
    input  master_req, pending, overflow, starve, busy
  );

endinterface

// File: rtl/req_queue_channel.sv
// One master's slice of the request queue: pending counter, sticky
// overflow flag, request FSM and no-grant wait counter.
//   clk, reset     : clock, synchronous active-high reset
//   client_req_i   : transaction pulse for this master
//   bus_grant_i    : this master's grant bit
//   bus_ack_i      : slave acknowledge
//   master_req_o   : pending count non-zero
//   pending_o      : pending count
//   overflow_o     : sticky overflow
//   starve_o       : waited TIMEOUT cycles without grant
//
// state      | meaning
// -----------+---------------------------------------------------
// RQ_IDLE    | nothing pending
// RQ_WAIT    | work pending, no grant held; wait counter running
// RQ_GRANTED | work pending and grant held
module req_channel import arbitration::*; #(
  parameter  int DEPTH   = 4,
  parameter  int TIMEOUT = 15,
  localparam int CW      = cnt_width(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          client_req_i,
  input  logic          bus_grant_i,
  input  logic          bus_ack_i,
  output logic          master_req_o,
  output logic [CW-1:0] pending_o,
  output logic          overflow_o,
  output logic          starve_o
);

  localparam int            WW        = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [WW-1:0] TIMEOUT_C = WW'(TIMEOUT);

  rq_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          ovf_q, ovf_d;
  logic          starve_q, starve_d;
  logic          done;

  always_comb begin
    // a grant+ack only completes something when there is something to complete
    done     = bus_grant_i & bus_ack_i & (cnt_q != '0);
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    state_d  = state_q;
    wait_d   = wait_q;
    starve_d = 1'b0;

    if (client_req_i && !done) begin
      if (cnt_q < DEPTH_C) cnt_d = cnt_q + CW'(1);
      else                 ovf_d = 1'b1;
    end else if (done && !client_req_i) begin
      cnt_d = cnt_q - CW'(1);
    end

    case (state_q)
      RQ_IDLE: begin
        if (cnt_d != '0) state_d = RQ_WAIT;
      end
      RQ_WAIT: begin
        // a completion sampled in the same cycle the grant first shows up
        // can drain the last entry; go straight home rather than sit in
        // GRANTED with nothing pending
        if (done && cnt_d == '0) state_d = RQ_IDLE;
        else if (bus_grant_i)    state_d = RQ_GRANTED;
      end
      RQ_GRANTED: begin
        if (done)              state_d = (cnt_d == '0) ? RQ_IDLE : RQ_WAIT;
        else if (!bus_grant_i) state_d = RQ_WAIT;
      end
      default: state_d = RQ_IDLE;
    endcase

    if (state_d != state_q && state_d != RQ_IDLE)
      wait_d = '0;
    else if (state_q == RQ_WAIT && !bus_grant_i && wait_q != TIMEOUT_C)
      wait_d = wait_q + WW'(1);

    // computed from next-state values so the flag lands on the same edge
    // the counter reaches TIMEOUT
    starve_d = (state_d == RQ_WAIT) && (wait_d == TIMEOUT_C);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RQ_IDLE;
      cnt_q    <= '0;
      wait_q   <= '0;
      ovf_q    <= 1'b0;
      starve_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wait_q   <= wait_d;
      ovf_q    <= ovf_d;
      starve_q <= starve_d;
    end
  end

  assign master_req_o = (cnt_q != '0);
  assign pending_o    = cnt_q;
  assign overflow_o   = ovf_q;
  assign starve_o     = starve_q;

endmodule

// File: rtl/req_queue.sv
// Per-master request queue in front of the bus masters. Turns client
// transaction pulses into level master requests held until every queued
// transaction completes (grant & ack), and flags overflow and starvation.
//   clk, reset : clock, synchronous active-high reset
//   bus        : req_queue_if slave modport (client pulses, bus taps,
//                master_req / pending / overflow / starve / busy)
module req_queue import arbitration::*; #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  req_queue_if.slave  bus
);

  localparam int CW = cnt_width(DEPTH);

  arb_vector                      mreq;
  arb_vector                      ovf;
  arb_vector                      stv;
  logic [NUM_MASTERS-1:0][CW-1:0] pend;

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_ch
    req_channel #(
      .DEPTH   (DEPTH),
      .TIMEOUT (TIMEOUT)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .client_req_i (bus.client_req[i]),
      .bus_grant_i  (bus.bus_grant[i]),
      .bus_ack_i    (bus.bus_ack),
      .master_req_o (mreq[i]),
      .pending_o    (pend[i]),
      .overflow_o   (ovf[i]),
      .starve_o     (stv[i])
    );
  end

  assign bus.master_req = mreq;
  assign bus.pending    = pend;
  assign bus.overflow   = ovf;
  assign bus.starve     = stv;
  assign bus.busy       = |mreq;

endmodule
